mem_req_ctrl: RTL
=================

Name: mem_req_ctrl

Overview:
- Request sequencer directly upstream of the single-port memory block (WIDTH-bit address, 2*WIDTH-bit data, strobed memoryWrite/memoryRead, registered read).
- Accepts one read or write per valid/ready handshake, drives the memory strobes, and captures read data one cycle after the address is presented.
- Holds read data in a one-entry response buffer until the consumer takes it.

Parameters:
WIDTH, 8, address width; data width is 2*WIDTH.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
req_valid  in  1  request present.
req_ready  out  1  request accepted when req_valid && req_ready.
req_write  in  1  1 = write, 0 = read.
req_addr  in  WIDTH  request address.
req_wdata  in  2*WIDTH  write data.
rsp_valid  out  1  read data valid.
rsp_ready  in  1  consumer accepts response.
rsp_data  out  2*WIDTH  read data.
memoryWrite  out  1  to memory write strobe.
memoryRead  out  1  to memory read/output enable.
memoryAddress  out  WIDTH  to memory address.
memoryWriteData  out  2*WIDTH  to memory write data.
memoryOutData  in  2*WIDTH  from memory; valid one cycle after its address, while memoryRead=1.
wr_err  out  1  sticky write-verify error (feature only; otherwise tied 0).

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0. This includes req_ready, rsp_valid, rsp_data, strobes, address, wdata and wr_err.
- req_ready=1 only in IDLE with the response buffer empty, or emptying this cycle (rsp_valid && rsp_ready).
- All memory outputs are registered. Strobes are 0 in every state not listed below.
- FSM:
  - IDLE: on a write handshake, register addr/wdata and go to WRITE. On a read handshake, register addr and go to RD_ADDR.
  - WRITE: memoryWrite=1 for exactly one cycle, address/data held. Then IDLE (or VERIFY_ADDR with the feature).
  - RD_ADDR: memoryRead=1, address driven. The memory latches mem[addr] at the end of this cycle. Go to RD_DATA.
  - RD_DATA: memoryRead=1 and address held. Capture memoryOutData into rsp_data at the end of this cycle, set rsp_valid, go to IDLE.
- Latency:
  - Write: handshake cycle N, memoryWrite in N+1; the next request can be accepted in N+2.
  - Read: handshake N, RD_ADDR N+1, RD_DATA N+2, rsp_valid=1 from N+3.
- Response buffer:
  - rsp_valid stays high and rsp_data stays stable until rsp_ready.
  - A new read is not accepted while the buffer is full and not draining, so no overwrite can occur.
  - Writes are also blocked by a full buffer; request ordering is preserved.
- Read-after-write to the same address returns the new data, because the write completes before the read is issued.
- rsp_ready while rsp_valid=0 is ignored.
- Reset mid-operation: the in-flight request is dropped, no response is produced, and strobes drop to 0 immediately.
- Address and data are passed through unchanged; no arithmetic, no address wrap.

Optional Feature:
- Macro: MEM_REQ_CTRL_WR_VERIFY_EN.
- Defined:
  - After WRITE, the FSM goes through VERIFY_ADDR then VERIFY_DATA. These behave like RD_ADDR/RD_DATA on the same address.
  - At the end of VERIFY_DATA, memoryOutData is compared with the registered wdata. On mismatch, wr_err is set (sticky until reset).
  - No response is produced.
  - Write latency grows by 2 cycles: the next request can be accepted in N+4.
- Undefined: no verify states exist and wr_err is constant 0.

Decomposition:
- Package mem_req_ctrl_pkg:
  - state enum: IDLE, WRITE, RD_ADDR, RD_DATA, VERIFY_ADDR, VERIFY_DATA.
  - localparam default WIDTH=8.
- Sub-module mem_req_rsp_buf: a one-entry valid/ready holding register (load, data, valid, ready, full).

Test Plan:
- Write 0xBEEF to addr 0x10, then read 0x10 -> memoryWrite high for exactly 1 cycle; rsp_valid 3 cycles after the read handshake with rsp_data=0xBEEF.
- Read an unwritten addr 0x55 after memory reset -> rsp_data=0x0000.
- Read 0x10 with rsp_ready=0 for 5 cycles, read 0x20 pending -> req_ready=0; rsp_data held at 0xBEEF; second read issued only after the rsp_ready handshake.
- Back-to-back writes 0x01→0x1111, 0x02→0x2222, then reads -> responses 0x1111, 0x2222 in order.
- Assert rst low during RD_DATA -> all outputs 0 asynchronously, no rsp_valid after release, next request accepted normally.
- With MEM_REQ_CTRL_WR_VERIFY_EN, force a memoryOutData mismatch in VERIFY_DATA -> wr_err=1 and stays 1 until reset; without the macro, wr_err=0 throughout.

Source files
------------

// File: rtl/mem_req_ctrl_pkg.sv
// Shared types and defaults for the mem_req_ctrl request sequencer.
`timescale 1ns/1ps
package mem_req_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ADDR,
        RD_DATA,
        VERIFY_ADDR,
        VERIFY_DATA
    } state_t;

    // States in which the memory output enable must be asserted.
    function automatic logic is_read_state(input state_t s);
        return (s == RD_ADDR) || (s == RD_DATA) || (s == VERIFY_ADDR) || (s == VERIFY_DATA);
    endfunction

endpackage

// File: rtl/mem_req_ctrl_if.sv
// Request/response handshake bundle between a requester (master) and mem_req_ctrl (slave).
`timescale 1ns/1ps
interface mem_req_ctrl_if
    import mem_req_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [WIDTH-1:0]     req_addr;
    logic [2*WIDTH-1:0]   req_wdata;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [2*WIDTH-1:0]   rsp_data;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/mem_req_rsp_buf.sv
// One-entry valid/ready holding register for read responses.
`timescale 1ns/1ps
module mem_req_rsp_buf
    import mem_req_ctrl_pkg::*;
#(
    parameter int unsigned DW = 2 * DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          ready,
    output logic          valid,
    output logic [DW-1:0] data,
    output logic          full
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

    assign full = valid;

endmodule

// File: rtl/mem_req_ctrl.sv
// Request sequencer in front of a single-port registered-read memory.
// Optional write-verify readback enabled by defining MEM_REQ_CTRL_WR_VERIFY_EN.
`timescale 1ns/1ps
module mem_req_ctrl
    import mem_req_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    mem_req_ctrl_if.slave      bus,
    output logic               memoryWrite,
    output logic               memoryRead,
    output logic [WIDTH-1:0]   memoryAddress,
    output logic [2*WIDTH-1:0] memoryWriteData,
    input  logic [2*WIDTH-1:0] memoryOutData,
    output logic               wr_err
);

    state_t               state;
    state_t               state_next;
    logic                 accept;
    logic                 buf_valid;
    logic                 buf_full;
    logic                 buf_drain;
    logic [2*WIDTH-1:0]   buf_data;

    assign buf_drain = buf_valid && bus.rsp_ready;

    // Gated by rst so ready is low while reset is held.
    assign bus.req_ready = rst && (state == IDLE) && (!buf_full || buf_drain);
    assign accept        = bus.req_valid && bus.req_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) state_next = bus.req_write ? WRITE : RD_ADDR;
            end
`ifdef MEM_REQ_CTRL_WR_VERIFY_EN
            WRITE:       state_next = VERIFY_ADDR;
`else
            WRITE:       state_next = IDLE;
`endif
            RD_ADDR:     state_next = RD_DATA;
            RD_DATA:     state_next = IDLE;
            VERIFY_ADDR: state_next = VERIFY_DATA;
            VERIFY_DATA: state_next = IDLE;
            default:     state_next = IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they are flop outputs aligned with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            memoryWrite     <= 1'b0;
            memoryRead      <= 1'b0;
            memoryAddress   <= '0;
            memoryWriteData <= '0;
        end else begin
            memoryWrite <= (state_next == WRITE);
            memoryRead  <= is_read_state(state_next);
            if (accept) begin
                memoryAddress <= bus.req_addr;
                if (bus.req_write) memoryWriteData <= bus.req_wdata;
            end
        end
    end

    mem_req_rsp_buf #(
        .DW (2 * WIDTH)
    ) u_rsp_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (state == RD_DATA),
        .load_data (memoryOutData),
        .ready     (bus.rsp_ready),
        .valid     (buf_valid),
        .data      (buf_data),
        .full      (buf_full)
    );

    assign bus.rsp_valid = buf_valid;
    assign bus.rsp_data  = buf_data;

`ifdef MEM_REQ_CTRL_WR_VERIFY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_err <= 1'b0;
        end else if ((state == VERIFY_DATA) && (memoryOutData != memoryWriteData)) begin
            wr_err <= 1'b1;
        end
    end
`else
    assign wr_err = 1'b0;
`endif

endmodule
